// File: rtl/dzcpu_dma_arbiter_pkg.sv
// Shared definitions for the OAM DMA arbiter: burst FSM states and default constants.
package dzcpu_dma_arbiter_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StRd,
        StWr,
        StDone
    } dma_state_e;

    localparam int unsigned DmaLenDefault     = 160;
    localparam logic [15:0] DmaRegAddrDefault = 16'hFF46;
    localparam logic [15:0] OamBaseDefault    = 16'hFE00;

endpackage

// File: rtl/dzcpu_dma_arbiter_idx_cnt.sv
// 8-bit up-counter with synchronous reset and enable; holds the DMA byte index.
module dzcpu_dma_arbiter_idx_cnt (
    input  logic       iClock,
    input  logic       iReset,
    input  logic       iEnable,
    output logic [7:0] oCount
);

    logic [7:0] cnt_d;
    logic [7:0] cnt_q;

    // Next count: advance only when enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (iEnable) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Count register; reset wins over enable.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign oCount = cnt_q;

endmodule

// File: rtl/dzcpu_dma_arbiter.sv
// Memory bus arbiter between the dzcpu core and the OAM DMA engine.
// Idle: CPU traffic passes straight through. A write to the DMA register starts a
// burst that copies DMA_LEN bytes from {src,8'h00} to OAM while stalling the CPU.
module dzcpu_dma_arbiter
    import dzcpu_dma_arbiter_pkg::*;
#(
    parameter int unsigned DMA_LEN      = DmaLenDefault,
    parameter logic [15:0] DMA_REG_ADDR = DmaRegAddrDefault,
    parameter logic [15:0] OAM_BASE     = OamBaseDefault
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic [15:0] iCpuAddr,
    input  logic [7:0]  iCpuData,
    input  logic        iCpuWe,
    output logic [7:0]  oCpuData,
    output logic        oCpuStall,
    output logic [15:0] oMemAddr,
    output logic [7:0]  oMemData,
    output logic        oMemWe,
    input  logic [7:0]  iMemData,
    output logic        oDmaActive
);

    localparam logic [7:0] LastIdx = 8'(DMA_LEN - 1);

    dma_state_e state_d, state_q;
    logic [7:0] src_d, src_q;
    logic [7:0] byte_d, byte_q;
    logic       stall_d, stall_q;
    logic [7:0] idx;
    logic       reg_hit;
    logic       trigger;
    logic       last_byte;
    logic       idx_reset;
    logic       idx_enable;

    assign reg_hit   = (iCpuAddr == DMA_REG_ADDR);
    // CPU inputs only matter while idle; a stalled CPU can never retrigger.
    assign trigger   = (state_q == StIdle) && iCpuWe && reg_hit;
    assign last_byte = (idx == LastIdx);

    assign idx_reset  = iReset | trigger;
    assign idx_enable = (state_q == StWr) && !last_byte;

    dzcpu_dma_arbiter_idx_cnt u_idx_cnt (
        .iClock  (iClock),
        .iReset  (idx_reset),
        .iEnable (idx_enable),
        .oCount  (idx)
    );

    // Next-state, source latch and read-byte capture for the burst sequencer.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        byte_d  = byte_q;
        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    state_d = StStart;
                    src_d   = iCpuData;
                end
            end
            StStart: state_d = StRd;
            StRd: begin
                byte_d  = iMemData;
                state_d = StWr;
            end
            StWr:    state_d = last_byte ? StDone : StRd;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Stall is registered alongside the state so it is high exactly when not idle.
        stall_d = (state_d != StIdle);
    end

    // Sequencer registers; synchronous reset has priority over a trigger write.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q <= StIdle;
            src_q   <= 8'd0;
            byte_q  <= 8'd0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            byte_q  <= byte_d;
            stall_q <= stall_d;
        end
    end

    // Bus mux: CPU passthrough when idle, DMA read/write cycles during a burst.
    always_comb begin
        oMemAddr = 16'h0000;
        oMemData = 8'h00;
        oMemWe   = 1'b0;
        unique case (state_q)
            StIdle: begin
                oMemAddr = iCpuAddr;
                oMemData = iCpuData;
                // The DMA register write is consumed here, never forwarded.
                oMemWe   = iCpuWe && !reg_hit;
            end
            StRd: begin
                oMemAddr = {src_q, idx};
            end
            StWr: begin
                oMemAddr = OAM_BASE + {8'h00, idx};
                oMemData = byte_q;
                oMemWe   = 1'b1;
            end
            default: begin
                oMemAddr = 16'h0000;
            end
        endcase
    end

    // CPU readback of the source register works in every state.
    always_comb begin
        oCpuData = reg_hit ? src_q : iMemData;
    end

    assign oCpuStall  = stall_q;
    assign oDmaActive = stall_q;

endmodule
